// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: frame header byte,
// frame FSM state encoding and the default UART bit period.
package imem_loader_pkg;

  // First byte of every program frame.
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // System clocks per UART bit: 50 MHz / 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  // Frame FSM state encoding.
  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_CNT  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_CSUM = 2'd3;

endpackage

// File: rtl/imem_loader_uart_rx_byte.sv
// 8N1 UART byte receiver. The line is synchronized, a falling edge starts
// the bit timer, and a one-cycle byte_valid or framing_err is produced at
// the stop-bit sample point.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  assign data = shift;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection;
  // all reset high so an idle line never looks like a start edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Bit timer and shifter: cnt holds cycles elapsed since the last sample
  // point, so the start check lands at HALF_BIT and later samples one full
  // bit apart; returning to idle right after the stop sample re-arms it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state    <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            cnt      <= CNT_ONE;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == HALF_BIT) begin
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              cnt      <= CNT_ONE;
              bit_idx  <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_BIT) begin
            shift <= {rx_sync, shift[7:1]};
            cnt   <= CNT_ONE;
            if (bit_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          if (cnt == FULL_BIT) begin
            if (rx_sync) begin
              byte_valid <= 1'b1;
            end else begin
              framing_err <= 1'b1;
            end
            rx_state <= RX_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: receives framed bytes over UART, assembles
// big-endian 32-bit words and writes them into instruction memory while
// holding the CPU, then releases it once the frame checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int MAX_WORDS    = 128
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx,
  output logic        wr_en,
  output logic [6:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [8:0] MAX_N = 9'(MAX_WORDS);

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ferr;

  logic [1:0]  state;
  logic [7:0]  word_cnt;
  logic [7:0]  next_addr;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [7:0]  csum;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx          (rx),
    .data        (rx_data),
    .byte_valid  (rx_valid),
    .framing_err (rx_ferr)
  );

  // Frame FSM with word assembly, address counter and running checksum.
  // A framing error aborts any frame in progress but leaves cpu_hold alone,
  // so a partially loaded program never runs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_HDR;
      word_cnt  <= '0;
      next_addr <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      csum      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (rx_ferr) begin
        if (state != ST_HDR) begin
          error <= 1'b1;
          state <= ST_HDR;
        end
      end else if (rx_valid) begin
        case (state)
          ST_HDR: begin
            if (rx_data == HDR_BYTE) begin
              cpu_hold <= 1'b1;
              done     <= 1'b0;
              error    <= 1'b0;
              state    <= ST_CNT;
            end
          end
          ST_CNT: begin
            if (rx_data == 8'd0 || {1'b0, rx_data} > MAX_N) begin
              error <= 1'b1;
              state <= ST_HDR;
            end else begin
              word_cnt  <= rx_data;
              next_addr <= '0;
              byte_idx  <= '0;
              csum      <= '0;
              state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            csum <= csum ^ rx_data;
            if (byte_idx == 2'd3) begin
              wr_en     <= 1'b1;
              wr_addr   <= next_addr[6:0];
              wr_data   <= {word_buf, rx_data};
              next_addr <= next_addr + 8'd1;
              byte_idx  <= '0;
              if (next_addr + 8'd1 == word_cnt) begin
                state <= ST_CSUM;
              end
            end else begin
              word_buf <= {word_buf[15:0], rx_data};
              byte_idx <= byte_idx + 2'd1;
            end
          end
          default: begin
            if (rx_data == csum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              error <= 1'b1;
            end
            state <= ST_HDR;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are sent over a modelled UART
// line, and the captured writes and flags are compared against a
// frame-level reference computed from the byte stream.
module tb_imem_loader;

  localparam int CPB       = 8;
  localparam int MAX_WORDS = 128;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [7:0]  tx_q[$];
  int          bad_stop_idx;
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_hold;
  logic        exp_done;
  logic        exp_err;

  imem_loader #(
    .CLKS_PER_BIT (CPB),
    .MAX_WORDS    (MAX_WORDS)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx       (rx),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  // Free-running system clock.
  always #5 clock = ~clock;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      cap_addr.push_back(32'(wr_addr));
      cap_data.push_back(wr_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic sendBit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stop);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(stop);
  endtask

  // Send tx_q back to back; the byte at bad_stop_idx gets a zero stop bit.
  task automatic applyStimulus();
    for (int i = 0; i < tx_q.size(); i++) begin
      sendByte(tx_q[i], (i == bad_stop_idx) ? 1'b0 : 1'b1);
    end
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
  endtask

  // Frame-level reference: which whole words of the frame reach memory and
  // how the frame ends, derived from the frame rules on the byte list.
  function automatic void expectFrame();
    int n;
    int last;
    int full;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    exp_hold = 1'b1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    last = (bad_stop_idx >= 0) ? bad_stop_idx : tx_q.size();
    if (last < 2) begin
      exp_err = (bad_stop_idx == 1);
      return;
    end
    n = int'(tx_q[1]);
    if (n == 0 || n > MAX_WORDS) begin
      exp_err = 1'b1;
      return;
    end
    full = (last - 2) / 4;
    if (full > n) full = n;
    for (int w = 0; w < full; w++) begin
      exp_addr.push_back(32'(w));
      exp_data.push_back({tx_q[2+4*w], tx_q[3+4*w], tx_q[4+4*w], tx_q[5+4*w]});
    end
    if (last <= 2 + 4 * n) begin
      exp_err = (bad_stop_idx >= 0);
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) x ^= tx_q[2+i];
    if (x == tx_q[2+4*n]) begin
      exp_done = 1'b1;
      exp_hold = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
  endfunction

  // Build a frame with the given count byte and number of random words.
  task automatic buildFrame(input logic [7:0] n, input int nwords, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    tx_q.delete();
    bad_stop_idx = -1;
    tx_q.push_back(8'hA5);
    tx_q.push_back(n);
    x = 8'h00;
    for (int i = 0; i < 4 * nwords; i++) begin
      b = 8'($urandom_range(0, 255));
      tx_q.push_back(b);
      x ^= b;
    end
    tx_q.push_back(corrupt ? ~x : x);
  endtask

  task automatic checkFrame(input string tag);
    int m;
    checkOutput($sformatf("%s.nwr", tag), 32'(cap_addr.size()), 32'(exp_addr.size()));
    m = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      checkOutput($sformatf("%s.addr%0d", tag, i), cap_addr[i], exp_addr[i]);
      checkOutput($sformatf("%s.data%0d", tag, i), cap_data[i], exp_data[i]);
    end
    checkOutput($sformatf("%s.hold", tag), 32'(cpu_hold), 32'(exp_hold));
    checkOutput($sformatf("%s.done", tag), 32'(done), 32'(exp_done));
    checkOutput($sformatf("%s.error", tag), 32'(error), 32'(exp_err));
  endtask

  task automatic runFrame(input string tag);
    cap_addr.delete();
    cap_data.delete();
    expectFrame();
    applyStimulus();
    checkFrame(tag);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput($sformatf("%s.wr_en", tag), 32'(wr_en), 32'd0);
    checkOutput($sformatf("%s.wr_addr", tag), 32'(wr_addr), 32'd0);
    checkOutput($sformatf("%s.wr_data", tag), wr_data, 32'd0);
    checkOutput($sformatf("%s.hold", tag), 32'(cpu_hold), 32'd0);
    checkOutput($sformatf("%s.done", tag), 32'(done), 32'd0);
    checkOutput($sformatf("%s.error", tag), 32'(error), 32'd0);
  endtask

  initial begin
    rx = 1'b1;
    reset_n = 1'b0;
    bad_stop_idx = -1;
    repeat (4) @(negedge clock);
    checkIdle("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    checkIdle("post_reset");

    $display("[TB] single word frame");
    tx_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    bad_stop_idx = -1;
    runFrame("single");

    $display("[TB] full depth frame");
    buildFrame(8'h80, 128, 1'b0);
    runFrame("full");

    $display("[TB] bad checksum");
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    bad_stop_idx = -1;
    runFrame("badcsum");

    $display("[TB] bad counts");
    tx_q = '{8'hA5, 8'h00};
    bad_stop_idx = -1;
    runFrame("cnt00");
    tx_q = '{8'hA5, 8'h81};
    runFrame("cnt81");
    buildFrame(8'h03, 3, 1'b0);
    runFrame("after_cnt");

    $display("[TB] stream noise");
    cap_addr.delete();
    cap_data.delete();
    rx = 1'b0;
    repeat (2) @(negedge clock);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    tx_q = '{8'hA5};
    bad_stop_idx = 0;
    applyStimulus();
    checkOutput("noise.nwr", 32'(cap_addr.size()), 32'd0);
    checkOutput("noise.hold", 32'(cpu_hold), 32'd0);
    checkOutput("noise.done", 32'(done), 32'd1);
    checkOutput("noise.error", 32'(error), 32'd0);
    buildFrame(8'h02, 2, 1'b0);
    runFrame("after_noise");
    buildFrame(8'h03, 3, 1'b0);
    while (tx_q.size() > 9) void'(tx_q.pop_back());
    bad_stop_idx = 8;
    runFrame("data_ferr");

    $display("[TB] random frames");
    for (int k = 0; k < 4; k++) begin
      int nw;
      nw = int'($urandom_range(1, 6));
      buildFrame(8'(nw), nw, ($urandom_range(0, 3) == 0));
      runFrame($sformatf("rand%0d", k));
    end

    $display("[TB] reset mid-frame");
    buildFrame(8'h02, 2, 1'b0);
    while (tx_q.size() > 5) void'(tx_q.pop_back());
    bad_stop_idx = -1;
    cap_addr.delete();
    cap_data.delete();
    applyStimulus();
    checkOutput("midreset.hold_before", 32'(cpu_hold), 32'd1);
    reset_n = 1'b0;
    #1;
    checkIdle("midreset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("midreset.nwr", 32'(cap_addr.size()), 32'd0);
    buildFrame(8'h02, 2, 1'b0);
    runFrame("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial program loader for the single-cycle CPU's instruction memory. It receives a framed UART byte stream from the host and assembles big-endian 32-bit words. Each word is written into instruction memory through a write port, while the CPU is held. It is the writer side of instruction memory, which the CPU datapath only ever reads.

## Interface
- CLKS_PER_BIT, default 5208: system clocks per UART bit (50 MHz / 9600 baud). Must be ≥ 4.
- MAX_WORDS, default 128: instruction memory depth in words, matching the 7-bit word address.
- clock  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx  in  1  UART line, idle high, 8N1, LSB first; asynchronous to clock.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  7  word address of the write.
- wr_data  out  32  word to write.
- cpu_hold  out  1  high while the CPU must be held in reset.
- done  out  1  sticky: last frame loaded with good checksum.
- error  out  1  sticky: last frame aborted (bad count, framing, or checksum).

## Operation
- Frame format: 0xA5 header, then count byte N (words, 1..MAX_WORDS), then 4·N data bytes (MSB first per word), then a checksum byte equal to the XOR of all 4·N data bytes.
- Byte receiver:
  - rx passes through a 2-flop synchronizer.
  - A falling edge starts a bit timer; rx is resampled at CLKS_PER_BIT/2.
  - If rx is high at that point, the start is a glitch and the receiver returns to idle silently.
  - Otherwise 8 data bits are sampled at CLKS_PER_BIT intervals, then the stop bit.
  - At the stop sample it emits a 1-cycle byte_valid with the byte, or framing_err if the stop bit is 0.
- Frame FSM states: HDR, CNT, DATA, CSUM.
  - HDR: a byte of 0xA5 → CNT and sets cpu_hold=1, done=0, error=0. Other bytes are ignored.
  - CNT: N=0 or N>MAX_WORDS → error=1, back to HDR. Otherwise latch N, clear word address, byte index and checksum, → DATA.
  - DATA: shift each byte into the word register and XOR it into the checksum. On the 4th byte, pulse wr_en with wr_addr=current address, then increment the address. After word N, → CSUM.
  - CSUM: on match, done=1, cpu_hold=0, → HDR. On mismatch, error=1, cpu_hold stays 1, → HDR.
- A framing error in any state except HDR gives error=1, → HDR, with cpu_hold unchanged. A framing error in HDR is ignored.
- Words already written before an abort stay written. The CPU stays held until a later frame completes cleanly.
- A new 0xA5 in HDR always restarts loading, even after done or error.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0 (CPU runs the resident program), done=0, error=0, FSM=HDR, receiver idle.
- Sample points relative to the first synchronized low sample (t=0):
  - Start check at CLKS_PER_BIT/2.
  - Bit k (k=0..7) at CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
  - Stop bit at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- The receiver re-arms for a new start edge on the cycle after the stop sample. Back-to-back bytes with zero idle time must be received.
- FSM latency: byte_valid in cycle c gives a registered response in cycle c+1. This covers wr_en, wr_data, wr_addr, cpu_hold, done and error.
- wr_addr and wr_data are stable during the wr_en cycle. wr_addr holds its value afterwards and the increment is internal.
- Reset asserted mid-frame: everything returns to reset values at once. cpu_hold drops to 0 and no partial write is issued.

## Structure
- Shared package: HDR_BYTE=8'hA5, the FSM state encoding (2 bits), and the default CLKS_PER_BIT.
- Sub-module uart_rx_byte contains the synchronizer, bit timer, shift register, byte_valid and framing_err. imem_loader instantiates it and holds the frame FSM, word assembly, address counter and checksum.

## Test plan
- Single word, CLKS_PER_BIT=8: send A5 01 12 34 56 78 08 → exactly one wr_en with addr 0, data 0x12345678. Then done=1, cpu_hold=0, error=0.
- Full depth: N=0x80 with 512 bytes, back-to-back, no idle → 128 writes at addresses 0..127, in order, with correct data. Then done=1.
- Bad checksum: A5 01 00 00 00 01 00 → one write of 0x00000001, then error=1, cpu_hold=1, done=0.
- Bad count: A5 00, and separately A5 81 → error=1, no wr_en, FSM back to HDR. A following valid frame clears error and loads.
- Stream noise: a glitch shorter than CLKS_PER_BIT/2 on idle rx, and a zero stop bit in HDR, are both ignored. A zero stop bit during DATA → error=1, with earlier words kept.
- Reset mid-frame: assert reset_n=0 after A5 02 and 3 data bytes → all outputs return to reset values. A new full frame then loads from address 0.
